// File: rtl/prime_seg_display.sv
// prime_seg_display: sequential double-dabble binary-to-BCD converter driving a
// six-digit multiplexed seven-segment display with leading-zero blanking.
module prime_seg_display #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] value,
    output logic [6:0]  seg,
    output logic [5:0]  an,
    output logic [23:0] bcd,
    output logic        busy,
    output logic        ovf
);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [19:0] MAX_DEC = 20'd999999;

    logic [19:0]   snapshot, operand;
    logic          pending, ovf_next, start, blank;
    logic [4:0]    iter;
    logic [23:0]   work, work_adj;
    logic [DW-1:0] div;
    logic [2:0]    idx;
    logic [3:0]    nib;
    logic [7:0]    zero_above;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign start = !busy && (pending || value != snapshot);

    always_comb begin
        work_adj = work;
        for (int i = 0; i < 6; i++)
            work_adj[4*i +: 4] = work[4*i +: 4] >= 4'd5 ? work[4*i +: 4] + 4'd3 : work[4*i +: 4];
    end

    // The committed result only moves on the final cycle so bcd never shows a partial value.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            pending  <= 1'b1;
            snapshot <= '0;
            bcd      <= '0;
            ovf      <= 1'b0;
            iter     <= '0;
            work     <= '0;
            operand  <= '0;
            ovf_next <= 1'b0;
        end else if (start) begin
            snapshot <= value;
            pending  <= 1'b0;
            busy     <= 1'b1;
            work     <= '0;
            iter     <= '0;
            operand  <= value > MAX_DEC ? MAX_DEC : value;
            ovf_next <= value > MAX_DEC;
        end else if (busy) begin
            if (iter == 5'd20) begin
                bcd  <= work;
                ovf  <= ovf_next;
                busy <= 1'b0;
            end else begin
                work    <= {work_adj[22:0], operand[19]};
                operand <= {operand[18:0], 1'b0};
                iter    <= iter + 5'd1;
            end
        end
    end

    // zero_above[i] is set when digit i and every digit above it are zero.
    always_comb begin
        zero_above    = 8'hff;
        zero_above[5] = bcd[23:20] == 4'd0;
        for (int i = 4; i >= 0; i--)
            zero_above[i] = zero_above[i+1] && bcd[4*i +: 4] == 4'd0;
        nib   = bcd[4*idx +: 4];
        blank = idx != 3'd0 && zero_above[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
            an  <= 6'b111110;
            seg <= 7'b1000000;
        end else begin
            div <= div == DIV_LAST ? '0 : div + 1'b1;
            if (div == DIV_LAST)
                idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
            an  <= ~(6'd1 << idx);
            seg <= blank ? 7'b1111111 : decode(nib);
        end
    end
endmodule
